// File: rtl/s_pe_out_stream_buf.sv
// Output stream buffer behind the streaming PEs.
// It captures len PE results into a DEPTH-entry FIFO and drains them as a valid/ready stream.
// Latency: a pushed word appears on out_data_o the cycle after its push.
// Backpressure: the registered pea_ready_req_o drops once occupancy would pass DEPTH-SKID.
// Optional stats (overflow_o, max_occ_o) are built only when S_OUT_BUF_STATS_EN is defined.
module s_pe_out_stream_buf #(
  parameter int N_BITS = 16,
  parameter int DEPTH  = 8,
  parameter int SKID   = 2,
  parameter int LEN_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       start_i,
  input  logic [LEN_W-1:0]           len_i,
  input  logic [N_BITS-1:0]          pe_res_i,
  input  logic                       pe_valid_i,
  input  logic                       pea_ready_i,
  output logic                       pea_ready_req_o,
  output logic [N_BITS-1:0]          out_data_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       overflow_o,
  output logic [$clog2(DEPTH):0]     max_occ_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [N_BITS-1:0]  mem [DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic [AW:0]        count, count_next;
  logic [LEN_W-1:0]   len_q, pushed, popped;
  logic               full, empty;
  logic               push_req, push_wr, pop;
  logic               ready_req_q;

  // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count      = wr_ptr - rd_ptr;

  // A stalled PE keeps valid high, so a token only counts when the array actually advanced.
  assign push_req   = pe_valid_i && pea_ready_i && (state == RUN) && (pushed < len_q);
  assign pop        = !empty && out_ready_i;
  // If the FIFO is full, a push still fits only when the same cycle also pops a word.
  assign push_wr    = push_req && (!full || pop);
  assign count_next = count + (AW+1)'(push_wr) - (AW+1)'(pop);

  assign out_valid_o     = !empty;
  assign out_data_o      = mem[rd_ptr[AW-1:0]];
  assign busy_o          = (state == RUN);
  assign done_o          = (state == DONE);
  assign pea_ready_req_o = ready_req_q;

  // FIFO storage: a data-only register file, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push_wr) mem[wr_ptr[AW-1:0]] <= pe_res_i;
  end

  // FIFO pointers: reset empties the buffer immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Ready request is registered, and SKID slots absorb the resulting one-cycle lag plus one in-flight result.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ready_req_q <= 1'b1;
    else if (state == RUN) ready_req_q <= (count_next <= (AW+1)'(DEPTH - SKID));
    else ready_req_q <= 1'b1;
  end

  // Transfer bookkeeping: latch the length on start and count accepted push tokens and pops.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      len_q  <= '0;
      pushed <= '0;
      popped <= '0;
    end else if (state == IDLE) begin
      if (start_i) begin
        len_q  <= len_i;
        pushed <= '0;
        popped <= '0;
      end
    end else if (state == RUN) begin
      if (push_req) pushed <= pushed + LEN_W'(1);
      if (pop)      popped <= popped + LEN_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_next;
  end

  // FSM next state: RUN ends on the pop that drains the final word.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start_i) state_next = (len_i == '0) ? DONE : RUN;
      RUN:  if (pop && ((popped + LEN_W'(1)) == len_q)) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef S_OUT_BUF_STATS_EN
  logic        overflow_q;
  logic [AW:0] max_occ_q;

  // Stats: overflow is sticky until reset, and peak occupancy restarts with each transfer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      overflow_q <= 1'b0;
      max_occ_q  <= '0;
    end else begin
      if (push_req && full && !pop) overflow_q <= 1'b1;
      if ((state == IDLE) && start_i) max_occ_q <= '0;
      else if (count_next > max_occ_q) max_occ_q <= count_next;
    end
  end

  assign overflow_o = overflow_q;
  assign max_occ_o  = max_occ_q;
`else
  assign overflow_o = 1'b0;
  assign max_occ_o  = '0;
`endif

endmodule

// File: tb/tb_s_pe_out_stream_buf.sv
// Self-checking bench for s_pe_out_stream_buf (DEPTH=8, SKID=2).
// Table-driven single-cycle vectors, plus hand-written multi-cycle sequences.
// Stimulus is driven 1ns after the rising edge, and outputs are checked 1ns after the next rising edge.
module tb_s_pe_out_stream_buf;

  logic        clk, rst_n, start, pe_valid, pea_ready, out_ready;
  logic [15:0] len, pe_res, out_data;
  logic        req, out_valid, busy, done, overflow;
  logic [3:0]  max_occ;

  int checks = 0;
  int failures = 0;

  s_pe_out_stream_buf #(.N_BITS(16), .DEPTH(8), .SKID(2), .LEN_W(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .len_i(len),
    .pe_res_i(pe_res), .pe_valid_i(pe_valid), .pea_ready_i(pea_ready),
    .pea_ready_req_o(req), .out_data_o(out_data), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .busy_o(busy), .done_o(done),
    .overflow_o(overflow), .max_occ_o(max_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef S_OUT_BUF_STATS_EN
  localparam logic STATS = 1'b1;
`else
  localparam logic STATS = 1'b0;
`endif

  typedef struct {
    logic        start;
    logic [15:0] len;
    logic        vld;
    logic [15:0] res;
    logic        prdy;
    logic        ordy;
    logic        e_ov;
    logic [15:0] e_od;
    logic        e_busy;
    logic        e_done;
    logic        e_req;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [15:0] l, input logic v, input logic [15:0] r,
                       input logic pr, input logic orr);
    start = s; len = l; pe_valid = v; pe_res = r; pea_ready = pr; out_ready = orr;
  endtask

  int  nxt, exp_pop, npop;
  logic seen;

  initial begin
    // T1 basic stream, len=4
    tbl[0]  = '{1'b1, 16'd4, 1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 16'd0,  1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 16'd0, 1'b1, 16'd1,  1'b1, 1'b1, 1'b1, 16'd1,  1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 16'd0, 1'b1, 16'd2,  1'b1, 1'b1, 1'b1, 16'd2,  1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 16'd0, 1'b1, 16'd3,  1'b1, 1'b1, 1'b1, 16'd3,  1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 16'd0, 1'b1, 16'd4,  1'b1, 1'b1, 1'b1, 16'd4,  1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 16'd0, 1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 16'd0,  1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 16'd0, 1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 16'd0,  1'b0, 1'b0, 1'b1};
    // T2 stall: valid held across pea_ready=0 cycles; restart attempt in RUN is ignored
    tbl[7]  = '{1'b1, 16'd3, 1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 16'd0, 1'b1, 16'd10, 1'b1, 1'b0, 1'b1, 16'd10, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 16'd0, 1'b1, 16'd11, 1'b0, 1'b0, 1'b1, 16'd10, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 16'd5, 1'b1, 16'd11, 1'b0, 1'b0, 1'b1, 16'd10, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 16'd0, 1'b1, 16'd11, 1'b0, 1'b0, 1'b1, 16'd10, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 16'd0, 1'b1, 16'd11, 1'b1, 1'b0, 1'b1, 16'd10, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 16'd0, 1'b1, 16'd12, 1'b1, 1'b1, 1'b1, 16'd11, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 16'd0, 1'b1, 16'd13, 1'b1, 1'b1, 1'b1, 16'd12, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 16'd0, 1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 16'd0,  1'b0, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 16'd0, 1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 16'd0,  1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_req", req, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_max_occ", max_occ, 0);
    rst_n = 1'b1;
    step();

    // T1/T2 vectors
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].start, tbl[i].len, tbl[i].vld, tbl[i].res, tbl[i].prdy, tbl[i].ordy);
      step();
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].e_od);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("vec%0d_done", i), done, tbl[i].e_done);
      chk($sformatf("vec%0d_req", i), req, tbl[i].e_req);
    end

    // T3 backpressure: pea_ready follows this block's request, and the sink is stalled
    drive(1, 10, 0, 0, 1, 0);
    step();
    nxt = 1;
    for (int i = 1; i <= 10; i++) begin
      drive(0, 0, 1, 16'(nxt), req, 0);
      if (pea_ready) nxt++;
      step();
      chk($sformatf("t3_req_c%0d", i), req, (i <= 6) ? 1 : 0);
    end
    chk("t3_pushed_words", nxt - 1, 7);
    chk("t3_head", out_data, 1);
    chk("t3_max_occ", max_occ, STATS ? 7 : 0);
    exp_pop = 1; seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      drive(0, 0, (nxt <= 10), 16'(nxt), req, 1);
      if (out_valid) begin
        chk("t3_pop_data", out_data, 16'(exp_pop));
        exp_pop++;
      end
      if (pe_valid && pea_ready) nxt++;
      step();
      seen = done;
    end
    chk("t3_done_seen", seen, 1);
    chk("t3_pop_count", exp_pop - 1, 10);
    chk("t3_overflow", overflow, 0);
    step();

    // T4 full FIFO: simultaneous push and pop, then a push without a pop is dropped
    drive(1, 12, 0, 0, 1, 0);
    step();
    for (int i = 1; i <= 8; i++) begin
      drive(0, 0, 1, 16'(i), 1, 0);
      step();
    end
    chk("t4_full_head", out_data, 1);
    drive(0, 0, 1, 16'd9, 1, 1);
    step();
    chk("t4_pushpop_head", out_data, 2);
    chk("t4_pushpop_overflow", overflow, 0);
    drive(0, 0, 1, 16'd10, 1, 0);
    step();
    chk("t4_drop_overflow", overflow, STATS ? 1 : 0);
    chk("t4_drop_head", out_data, 2);
    drive(0, 0, 0, 0, 1, 0);
    step();
    chk("t4_overflow_sticky", overflow, STATS ? 1 : 0);
    exp_pop = 2; npop = 0;
    for (int c = 0; c < 20 && out_valid; c++) begin
      drive(0, 0, 0, 0, 1, 1);
      chk("t4_pop_data", out_data, 16'(exp_pop));
      exp_pop++; npop++;
      step();
    end
    chk("t4_pop_count", npop, 8);
    chk("t4_still_busy", busy, 1);
    drive(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_overflow", overflow, 0);
    chk("t4_rst_busy", busy, 0);
    #10 rst_n = 1'b1;
    step();

    // T6 async reset with 3 words stored, then a clean restart
    drive(1, 5, 0, 0, 1, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 16'(100 + i), 1, 0);
      step();
    end
    drive(0, 0, 0, 0, 1, 0);
    chk("t6_pre_head", out_data, 100);
    chk("t6_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_req", req, 1);
    chk("t6_rst_max_occ", max_occ, 0);
    #10 rst_n = 1'b1;
    step();
    drive(1, 2, 0, 0, 1, 1);
    step();
    chk("t6_restart_busy", busy, 1);
    chk("t6_restart_empty", out_valid, 0);
    drive(0, 0, 1, 16'd21, 1, 1);
    step();
    chk("t6_word0", out_data, 21);
    drive(0, 0, 1, 16'd22, 1, 1);
    step();
    chk("t6_word1", out_data, 22);
    drive(0, 0, 0, 0, 1, 1);
    step();
    chk("t6_done", done, 1);
    chk("t6_empty", out_valid, 0);
    step();

    // T5 len=0 goes straight to DONE and accepts no push
    drive(1, 0, 1, 16'd55, 1, 0);
    step();
    chk("t5_done", done, 1);
    chk("t5_busy", busy, 0);
    chk("t5_out_valid", out_valid, 0);
    drive(0, 0, 1, 16'd55, 1, 0);
    step();
    chk("t5_done_pulse", done, 0);
    chk("t5_no_push", out_valid, 0);
    chk("t5_overflow", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
